ram_burst_ctrl: RTL and testbench

Burst controller that sits directly upstream of `single_port_ram` and is the only agent driving its `data`/`addr`/`we` pins and consuming its `q`. It accepts one command at a time (write or read, start address, length), streams write beats into consecutive RAM words, and streams read data out through valid/ready with backpressure. The RAM's two-cycle registered read latency is absorbed by an internal credit-controlled skid FIFO.

---
 rtl/ram_burst_pkg.sv | 15 +
 rtl/rd_skid_fifo.sv | 71 +++++++
 rtl/ram_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst controller.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int RD_LATENCY    = 2;
  localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/rd_skid_fifo.sv
// Read-return skid FIFO; rd_data is a register holding the current head.
module rd_skid_fifo
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [RD_CNT_W-1:0]   count,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d, rptr_nx;
  logic [RD_CNT_W-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push &&
              ((count_q != RD_CNT_W'(RD_FIFO_DEPTH)) || pop_ok);
    rptr_nx = rptr_q + PW'(1);
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_nx : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + RD_CNT_W'(1);
      2'b01:   count_d = count_q - RD_CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head register follows the entry that will be at rptr next cycle
    rd_data_d = rd_data_q;
    if (count_q == '0) begin
      if (push_ok) rd_data_d = push_data;
    end else if (pop_ok) begin
      if (count_q > RD_CNT_W'(1)) rd_data_d = mem[rptr_nx];
      else if (push_ok)           rd_data_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign count    = count_q;
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst write/read controller in front of a 2-cycle-latency single-port RAM.
// Define RAM_BURST_CTRL_WRAP_EN to let bursts wrap past the top address.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int UW = RD_CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  cmd_hs, wr_hs, pop, issue, range_err;
  logic [UW-1:0]         used;
  logic [RD_CNT_W-1:0]   fifo_count;

`ifdef RAM_BURST_CTRL_WRAP_EN
  assign range_err = 1'b0;
`else
  logic [ADDR_WIDTH:0] end_addr;
  assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign range_err = end_addr[ADDR_WIDTH];
`endif

  assign cmd_ready = (state_q == IDLE) && !done_q && !err_q;
  assign wr_ready  = (state_q == WRITE);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign wr_hs     = wr_ready && wr_valid;
  assign pop       = rd_valid && rd_ready;

  // Credit: FIFO slots not yet claimed by held or in-flight beats
  assign used  = UW'(fifo_count) + UW'($countones(pipe_q));
  assign issue = (state_q == READ) && (used < UW'(RD_FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    beats_left_d = beats_left_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pipe_d       = {pipe_q[RD_LATENCY-2:0], issue};
    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (range_err) begin
            err_d = 1'b1;
          end else begin
            addr_cnt_d   = cmd_addr;
            beats_left_d = cmd_len;
            state_d      = cmd_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
          if (beats_left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beats_left_d = beats_left_q - ADDR_WIDTH'(1);
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
          if (beats_left_q == '0) state_d = DRAIN;
          else beats_left_d = beats_left_q - ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (pipe_q == '0 &&
            (fifo_count == '0 ||
             (fifo_count == RD_CNT_W'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_cnt_q   <= '0;
      beats_left_q <= '0;
      pipe_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      beats_left_q <= beats_left_d;
      pipe_q       <= pipe_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign ram_we   = wr_hs;
  assign ram_addr = addr_cnt_q;
  assign ram_data = (state_q == WRITE) ? wr_data : '0;

  rd_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pipe_q[RD_LATENCY-1]),
    .push_data(ram_q),
    .pop      (pop),
    .count    (fifo_count),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 2-cycle RAM.
// Honours RAM_BURST_CTRL_WRAP_EN for the boundary-crossing case.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        done, err;
  logic [15:0] ram_data;
  logic [4:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_q = '0;

  logic [15:0] mem [32];
  logic [15:0] exp_mem [32];
  logic [4:0]  a_r = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  // Registered address, registered output: two-cycle read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    a_r   <= ram_addr;
    ram_q <= mem[a_r];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_cmd(input logic w, input logic [4:0] a,
                          input logic [4:0] l);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("cmd_ready_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [4:0] a, input logic [4:0] l,
                             input logic [15:0] base,
                             input int gap_at, input int gap_len);
    logic [4:0] wa;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          wr_valid = 1'b0;
          #1 check("gap_no_we", ram_we, 0);
          @(negedge clk);
        end
      end
      wa       = a + 5'(i);
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      #1;
      check("wr_ready", wr_ready, 1);
      check("wr_addr", ram_addr, wa);
      exp_mem[wa] = base + 16'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1 check("wr_done", done, 1);
    @(negedge clk);
    check("wr_done_once", done, 0);
  endtask

  task automatic read_burst(input logic [4:0] a, input logic [4:0] l,
                            input logic tog);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int maxc = 0;
    int early = 0;
    logic [4:0] ra;
    send_cmd(1'b0, a, l);
    while (got <= int'(l) && cyc < 400) begin
      rd_ready = tog ? (cyc % 2 == 0) : 1'b1;
      if (int'(dut.u_fifo.count_q) > maxc)
        maxc = int'(dut.u_fifo.count_q);
      if (done) early++;
      if (rd_valid && first < 0) first = cyc;
      if (rd_valid && rd_ready) begin
        ra = a + 5'(got);
        check("rd_data", rd_data, exp_mem[ra]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_beats", got, int'(l) + 1);
    check("rd_first_lat", first, 3);
    check("rd_fifo_max_le4", maxc <= 4, 1);
    check("rd_no_early_done", early, 0);
    check("rd_done", done, 1);
    @(negedge clk);
    check("rd_done_once", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd;
    logic [31:0] outs;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    outs = {cmd_ready, wr_ready, rd_valid, done, err, ram_we,
            ram_addr, 5'b0, ram_data[3:0]};
    check("reset_ctl", outs, {6'b100000, 10'b0, 4'b0});
    check("reset_rd_data", rd_data, 0);
    check("reset_ram_data", ram_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    write_burst(5'd2, 5'd3, 16'hA000, -1, 0);
    check("mem_a2", mem[2], 16'hA000);
    check("mem_a5", mem[5], 16'hA003);
    read_burst(5'd2, 5'd3, 1'b0);

    write_burst(5'd0, 5'd31, 16'hB000, -1, 0);
    read_burst(5'd0, 5'd31, 1'b1);

`ifdef RAM_BURST_CTRL_WRAP_EN
    write_burst(5'd30, 5'd3, 16'hC000, -1, 0);
    check("wrap_mem0", mem[0], 16'hC002);
    read_burst(5'd30, 5'd3, 1'b0);
`else
    send_cmd(1'b1, 5'd30, 5'd3);
    check("err_pulse", err, 1);
    check("err_no_we", ram_we, 0);
    check("err_busy", cmd_ready, 0);
    @(negedge clk);
    check("err_once", err, 0);
    check("err_idle", cmd_ready, 1);
    check("err_wr_ready", wr_ready, 0);
    check("err_mem30", mem[30], 16'hB01E);
    check("err_mem31", mem[31], 16'hB01F);
    check("err_mem0", mem[0], 16'hB000);
    check("err_mem1", mem[1], 16'hB001);
`endif

    write_burst(5'd10, 5'd3, 16'hD000, 2, 5);
    read_burst(5'd10, 5'd3, 1'b0);

    // Reset while the second read beat is being presented
    send_cmd(1'b0, 5'd0, 5'd5);
    rd_ready = 1'b1;
    nd = 0;
    while (!rd_valid && nd < 20) begin
      @(negedge clk);
      nd++;
    end
    @(negedge clk);
    check("rst_beat2_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    outs = {cmd_ready, wr_ready, rd_valid, done, err, ram_we,
            ram_addr, 5'b0, ram_data[3:0]};
    check("midrst_ctl", outs, {6'b100000, 10'b0, 4'b0});
    check("midrst_rd_data", rd_data, 0);
    check("midrst_ram_data", ram_data, 0);
    rd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    check("midrst_ready", cmd_ready, 1);

    write_burst(5'd31, 5'd0, 16'hFFFF, -1, 0);
    read_burst(5'd31, 5'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
